// File: rtl/change_txn_ctrl.sv
// Coin-change transaction controller: collects coins against a latched cost,
// then pays change greedily (5/3/1) from a registered inventory, one coin per handshake.
module change_txn_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       Start,
   input  logic [3:0] Cost,
   input  logic       CoinValid,
   input  logic [2:0] CoinValue,
   input  logic       Cancel,
   input  logic       Restock,
   input  logic [1:0] RestockP,
   input  logic [1:0] RestockT,
   input  logic [1:0] RestockC,
   input  logic       DispReady,
   output logic       DispValid,
   output logic [2:0] DispCoin,
   output logic [3:0] Paid,
   output logic [3:0] Remaining,
   output logic [1:0] Pentagons,
   output logic [1:0] Triangles,
   output logic [1:0] Circles,
   output logic       Busy,
   output logic       CoughUpMore,
   output logic       ExactAmount,
   output logic       NotEnoughChange,
   output logic       CoinReject,
   output logic       Done
);

   localparam int unsigned W_AMT  = 4;
   localparam int unsigned W_SUM  = W_AMT + 1;
   localparam int unsigned W_COIN = 3;
   localparam int unsigned W_INV  = 2;

   localparam logic [W_COIN-1:0] COIN_P   = W_COIN'(5);
   localparam logic [W_COIN-1:0] COIN_T   = W_COIN'(3);
   localparam logic [W_COIN-1:0] COIN_C   = W_COIN'(1);
   localparam logic [W_SUM-1:0]  MAX_PAID = W_SUM'(15);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_DISPENSE = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [W_AMT-1:0]   r_cost;
   logic [W_AMT-1:0]   r_paid;
   logic [W_AMT-1:0]   r_remaining;
   logic [W_INV-1:0]   r_pent;
   logic [W_INV-1:0]   r_tri;
   logic [W_INV-1:0]   r_circ;
   logic               r_exact;
   logic               r_nec;
   logic               r_coin_reject;

   logic [W_COIN-1:0]  w_sel;
   logic               w_disp_valid;
   logic               w_handshake;
   logic [W_SUM-1:0]   w_sum;
   logic               w_coin_legal;
   logic               w_coin_ok;
   logic               w_paid_done;
   logic               w_start_ok;

   // Greedy coin selection from registered Remaining and inventory
   always_comb begin
      w_sel = '0;
      if (r_state == S_DISPENSE) begin
         if (r_remaining >= W_AMT'(COIN_P) && r_pent != '0)
            w_sel = COIN_P;
         else if (r_remaining >= W_AMT'(COIN_T) && r_tri != '0)
            w_sel = COIN_T;
         else if (r_remaining >= W_AMT'(COIN_C) && r_circ != '0)
            w_sel = COIN_C;
      end
   end

   assign w_disp_valid = (w_sel != '0);
   assign w_handshake  = w_disp_valid && DispReady;
   assign w_sum        = {1'b0, r_paid} + W_SUM'(CoinValue);
   assign w_coin_legal = (CoinValue == COIN_C) || (CoinValue == COIN_T) || (CoinValue == COIN_P);
   assign w_coin_ok    = w_coin_legal && (w_sum <= MAX_PAID);
   assign w_paid_done  = (r_paid >= r_cost);
   assign w_start_ok   = Start && !Restock && (Cost != '0);

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_COLLECT;
         end
         S_COLLECT: begin
            if (Cancel)
               w_next = (r_paid == '0) ? S_DONE : S_DISPENSE;
            else if (w_paid_done)
               w_next = (r_paid == r_cost) ? S_DONE : S_DISPENSE;
         end
         S_DISPENSE: begin
            if (!w_disp_valid) w_next = S_DONE;
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: cost, paid, change owed, inventory and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cost        <= '0;
         r_paid        <= '0;
         r_remaining   <= '0;
         r_pent        <= '0;
         r_tri         <= '0;
         r_circ        <= '0;
         r_exact       <= 1'b0;
         r_nec         <= 1'b0;
         r_coin_reject <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (Restock) begin
                  r_pent <= RestockP;
                  r_tri  <= RestockT;
                  r_circ <= RestockC;
               end else if (w_start_ok) begin
                  r_cost      <= Cost;
                  r_paid      <= '0;
                  r_remaining <= '0;
                  r_exact     <= 1'b0;
                  r_nec       <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (Cancel) begin
                  r_remaining   <= r_paid;
                  r_coin_reject <= CoinValid;
               end else if (w_paid_done) begin
                  if (r_paid == r_cost) r_exact     <= 1'b1;
                  else                  r_remaining <= r_paid - r_cost;
                  r_coin_reject <= CoinValid;
               end else if (CoinValid) begin
                  if (w_coin_ok) r_paid        <= w_sum[W_AMT-1:0];
                  else           r_coin_reject <= 1'b1;
               end
            end
            S_DISPENSE: begin
               r_coin_reject <= CoinValid;
               if (w_handshake) begin
                  r_remaining <= r_remaining - W_AMT'(w_sel);
                  if (w_sel == COIN_P)      r_pent <= r_pent - W_INV'(1);
                  else if (w_sel == COIN_T) r_tri  <= r_tri - W_INV'(1);
                  else                      r_circ <= r_circ - W_INV'(1);
               end else if (!w_disp_valid) begin
                  r_nec <= (r_remaining != '0);
               end
            end
            S_DONE: ;
            default: ;
         endcase
      end
   end

   // Output decode from registered state
   always_comb begin
      DispValid   = 1'b0;
      DispCoin    = '0;
      Busy        = 1'b0;
      CoughUpMore = 1'b0;
      Done        = 1'b0;
      if (r_state != S_IDLE) Busy = 1'b1;
      if (r_state == S_COLLECT && !w_paid_done) CoughUpMore = 1'b1;
      if (r_state == S_DONE) Done = 1'b1;
      if (w_disp_valid) begin
         DispValid = 1'b1;
         DispCoin  = w_sel;
      end
   end

   assign Paid            = r_paid;
   assign Remaining       = r_remaining;
   assign Pentagons       = r_pent;
   assign Triangles       = r_tri;
   assign Circles         = r_circ;
   assign ExactAmount     = r_exact;
   assign NotEnoughChange = r_nec;
   assign CoinReject      = r_coin_reject;

endmodule
